reg_dump_reader: RTL and testbench

REG_DUMP_READER -- requirements
Module: reg_dump_reader

---
 rtl/reg_dump_reader.sv | 214 +++++++++++++++++++++
 tb/tb_reg_dump_reader.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/reg_dump_reader.sv
// reg_dump_reader
//   Walks a register file from a latched first address to a latched last
//   address (wrapping modulo 2**n) through a combinational read port and
//   presents each register as an (address, data) word on a valid/ready
//   output. It pulses done once the last word has been accepted. abort
//   cancels a dump at any point. Each word costs at least two cycles: one
//   to read and one to hold.
//
// Ports
//   clk         single clock, all state changes on its rising edge
//   rst_n       asynchronous active-low reset
//   start       dump request, only looked at while idle
//   abort       cancels a dump in progress; wins over start and out_ready
//   first_addr  first register to read, latched on an accepted start
//   last_addr   last register to read, latched on an accepted start
//   rd_addr     read address for the register-file read port
//   rd_data     combinational read data for rd_addr
//   out_valid   out_addr/out_data carry a word
//   out_ready   downstream takes the word while out_valid is high
//   out_addr    register index of the presented word
//   out_data    captured register contents
//   busy        high whenever the block is not idle
//   done        single-cycle pulse after the last word is accepted

module reg_dump_reader #(
    parameter int n = 5,
    parameter int m = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         abort,
    input  logic [n-1:0] first_addr,
    input  logic [n-1:0] last_addr,
    output logic [n-1:0] rd_addr,
    input  logic [m-1:0] rd_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [n-1:0] out_addr,
    output logic [m-1:0] out_data,
    output logic         busy,
    output logic         done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_HOLD = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [n-1:0] ONE_C = {{(n-1){1'b0}}, 1'b1};

    state_t         state_r;
    state_t         state_s;
    logic [n-1:0]   cnt_r;
    logic [n-1:0]   cnt_s;
    logic [n-1:0]   first_r;
    logic [n-1:0]   first_s;
    logic [n-1:0]   last_r;
    logic [n-1:0]   last_s;
    logic           out_valid_r;
    logic           out_valid_s;
    logic [n-1:0]   out_addr_r;
    logic [n-1:0]   out_addr_s;
    logic [m-1:0]   out_data_r;
    logic [m-1:0]   out_data_s;
    logic           busy_r;
    logic           busy_s;
    logic           done_r;
    logic           done_s;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic; abort always wins over start and out_ready
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_s = ST_READ;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_READ: begin
                if (abort) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (abort) begin
                    state_s = ST_IDLE;
                end else if (out_ready && (cnt_r != last_r)) begin
                    state_s = ST_READ;
                end else if (out_ready) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_HOLD;
                end
            end
            ST_DONE: begin
                if (abort) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // FSM outputs: next values of the counter, latched range and output word.
    // Every return to idle reloads the counter from the latched first address
    // so rd_addr shows that address while idle.
    always_comb begin
        cnt_s       = cnt_r;
        first_s     = first_r;
        last_s      = last_r;
        out_valid_s = out_valid_r;
        out_addr_s  = out_addr_r;
        out_data_s  = out_data_r;
        case (state_r)
            ST_IDLE: begin
                out_valid_s = 1'b0;
                if (start && !abort) begin
                    first_s = first_addr;
                    last_s  = last_addr;
                    cnt_s   = first_addr;
                end else begin
                    cnt_s   = first_r;
                end
            end
            ST_READ: begin
                if (abort) begin
                    cnt_s       = first_r;
                    out_valid_s = 1'b0;
                end else begin
                    out_valid_s = 1'b1;
                    out_addr_s  = cnt_r;
                    out_data_s  = rd_data;
                end
            end
            ST_HOLD: begin
                if (abort) begin
                    cnt_s       = first_r;
                    out_valid_s = 1'b0;
                end else if (out_ready) begin
                    out_valid_s = 1'b0;
                    if (cnt_r != last_r) begin
                        // natural n-bit overflow gives the wrap to 0
                        cnt_s = cnt_r + ONE_C;
                    end else begin
                        cnt_s = cnt_r;
                    end
                end else begin
                    out_valid_s = 1'b1;
                end
            end
            ST_DONE: begin
                cnt_s       = first_r;
                out_valid_s = 1'b0;
            end
            default: begin
                cnt_s       = first_r;
                out_valid_s = 1'b0;
            end
        endcase
        busy_s = (state_s != ST_IDLE);
        done_s = (state_s == ST_DONE);
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r       <= {n{1'b0}};
            first_r     <= {n{1'b0}};
            last_r      <= {n{1'b0}};
            out_valid_r <= 1'b0;
            out_addr_r  <= {n{1'b0}};
            out_data_r  <= {m{1'b0}};
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            cnt_r       <= cnt_s;
            first_r     <= first_s;
            last_r      <= last_s;
            out_valid_r <= out_valid_s;
            out_addr_r  <= out_addr_s;
            out_data_r  <= out_data_s;
            busy_r      <= busy_s;
            done_r      <= done_s;
        end
    end

    assign rd_addr   = cnt_r;
    assign out_valid = out_valid_r;
    assign out_addr  = out_addr_r;
    assign out_data  = out_data_r;
    assign busy      = busy_r;
    assign done      = done_r;

endmodule

// File: tb/tb_reg_dump_reader.sv
module tb_reg_dump_reader;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [4:0]  first_addr;
    logic [4:0]  last_addr;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_addr;
    logic [31:0] out_data;
    logic        busy;
    logic        done;

    logic [31:0] regs [32];
    int          n_checks;
    int          n_fails;

    typedef struct {
        logic [4:0] f;
        logic [4:0] l;
        int         mode;   // 0: ready always, 1: random ready, 2: ready low 5 cycles per word
        int         words;
        bit         noise;  // pulse start while busy
    } vec_t;

    vec_t tbl [6];

    reg_dump_reader #(.n(5), .m(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .first_addr (first_addr),
        .last_addr  (last_addr),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_addr   (out_addr),
        .out_data   (out_data),
        .busy       (busy),
        .done       (done)
    );

    assign rd_data = regs[rd_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Runs one dump and compares it with the word list the bench derives
    // from the range: addresses first, first+1, ... wrapping at 32.
    task automatic run_dump(input logic [4:0] f, input logic [4:0] l, input int mode,
                            input int exp_words, input bit noise);
        int         exp_addr [$];
        int         n_words;
        int         acc;
        int         last_acc;
        int         done_cyc;
        int         ndone;
        int         vcount;
        bit         pv;
        logic [4:0]  pa;
        logic [31:0] pd;
        acc = 0; last_acc = -10; done_cyc = -1; ndone = 0; vcount = 0; pv = 1'b0;
        pa = 5'd0; pd = 32'd0;
        n_words = ((int'(l) - int'(f) + 32) % 32) + 1;
        for (int k = 0; k < n_words; k++) exp_addr.push_back((int'(f) + k) % 32);
        check("model_word_count", 64'(n_words), 64'(exp_words));

        @(negedge clk);
        start = 1'b1; abort = 1'b0; first_addr = f; last_addr = l; out_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        first_addr = 5'($urandom); last_addr = 5'($urandom);
        check("busy_after_start", 64'(busy), 64'd1);
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (cyc > 0) @(negedge clk);
            start = noise && (cyc == 3);
            if (done) begin
                ndone++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (done_cyc >= 0 && cyc == done_cyc + 1) begin
                check("done_width", 64'(done), 64'd0);
                check("busy_after_done", 64'(busy), 64'd0);
                break;
            end
            if (pv && out_valid) begin
                check("hold_addr_stable", 64'(out_addr), 64'(pa));
                check("hold_data_stable", 64'(out_data), 64'(pd));
            end
            case (mode)
                0: out_ready = 1'b1;
                1: out_ready = 1'($urandom_range(0, 1));
                default: out_ready = (vcount >= 5);
            endcase
            if (out_valid && out_ready) begin
                if (acc < exp_addr.size()) begin
                    check("word_addr", 64'(out_addr), 64'(exp_addr[acc]));
                    check("word_data", 64'(out_data), 64'(regs[exp_addr[acc]]));
                end
                if (mode == 0 && acc > 0) check("word_spacing", 64'(cyc - last_acc), 64'd2);
                if (mode == 2) check("valid_hold_cycles", 64'(vcount + 1), 64'd6);
                acc++;
                last_acc = cyc;
                vcount = 0;
                pv = 1'b0;
            end else begin
                if (out_valid) vcount++;
                pv = out_valid;
                pa = out_addr;
                pd = out_data;
            end
        end
        start = 1'b0;
        out_ready = 1'b0;
        check("words_delivered", 64'(acc), 64'(exp_words));
        check("done_pulses", 64'(ndone), 64'd1);
        check("done_after_last_accept", 64'(done_cyc), 64'(last_acc + 1));
        check("idle_rd_addr", 64'(rd_addr), 64'(f));
    endtask

    initial begin
        int vc;
        logic [4:0] rf;
        logic [4:0] rl;
        n_checks = 0; n_fails = 0;
        for (int i = 0; i < 32; i++) regs[i] = 32'hA000_0000 + 32'(i);
        tbl[0] = '{5'd4,  5'd7,  0, 4,  1'b0};
        tbl[1] = '{5'd30, 5'd1,  0, 4,  1'b0};
        tbl[2] = '{5'd17, 5'd17, 2, 1,  1'b0};
        tbl[3] = '{5'd9,  5'd9,  0, 1,  1'b0};
        tbl[4] = '{5'd5,  5'd4,  1, 32, 1'b0};
        tbl[5] = '{5'd4,  5'd7,  0, 4,  1'b1};

        rst_n = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
        first_addr = 5'd0; last_addr = 5'd0;
        #1;
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_rd_addr", 64'(rd_addr), 64'd0);
        check("reset_out_data", 64'(out_data), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_valid", 64'(out_valid), 64'd0);

        for (int t = 0; t < 6; t++) run_dump(tbl[t].f, tbl[t].l, tbl[t].mode, tbl[t].words, tbl[t].noise);

        // start together with abort in idle is ignored
        @(negedge clk);
        start = 1'b1; abort = 1'b1; first_addr = 5'd12; last_addr = 5'd20;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check("start_abort_busy", 64'(busy), 64'd0);
        check("start_abort_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        check("start_abort_busy2", 64'(busy), 64'd0);
        run_dump(5'd4, 5'd7, 0, 4, 1'b0);

        // abort while the third word is held, with out_ready also high
        @(negedge clk);
        start = 1'b1; first_addr = 5'd0; last_addr = 5'd31;
        @(negedge clk);
        start = 1'b0; out_ready = 1'b1; vc = 0;
        for (int cyc = 0; cyc < 50; cyc++) begin
            if (out_valid) vc++;
            if (vc == 3) begin
                abort = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("abort_reached_word3", 64'(vc), 64'd3);
        @(negedge clk);
        abort = 1'b0; out_ready = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_valid", 64'(out_valid), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_rd_addr", 64'(rd_addr), 64'd0);
        for (int cyc = 0; cyc < 4; cyc++) begin
            @(negedge clk);
            check("abort_quiet", 64'({out_valid, done, busy}), 64'd0);
        end

        // reset in the middle of a dump, then a fresh 2-word dump
        @(negedge clk);
        start = 1'b1; first_addr = 5'd8; last_addr = 5'd31;
        @(negedge clk);
        start = 1'b0; out_ready = 1'b1;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midreset_valid", 64'(out_valid), 64'd0);
        check("midreset_addr", 64'(out_addr), 64'd0);
        check("midreset_data", 64'(out_data), 64'd0);
        check("midreset_busy", 64'(busy), 64'd0);
        check("midreset_rd_addr", 64'(rd_addr), 64'd0);
        @(negedge clk);
        check("midreset_done", 64'(done), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int cyc = 0; cyc < 3; cyc++) begin
            @(negedge clk);
            check("post_reset_quiet", 64'({out_valid, done, busy}), 64'd0);
        end
        out_ready = 1'b0;
        run_dump(5'd2, 5'd3, 0, 2, 1'b0);

        // random register contents and ranges with random back-pressure
        for (int i = 0; i < 32; i++) regs[i] = $urandom;
        for (int t = 0; t < 6; t++) begin
            rf = 5'($urandom);
            rl = 5'($urandom);
            run_dump(rf, rl, 1, ((int'(rl) - int'(rf) + 32) % 32) + 1, 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
